clock_disp: RTL and testbench

//  Timebase and display front-end for the stopwatch top level. Divides the board clock into

---
 rtl/clock_disp_pkg.sv | 29 ++
 rtl/clock_disp_if.sv | 32 +++
 rtl/clock_disp_seg_mux.sv | 62 ++++++
 rtl/clock_disp.sv | 82 ++++++++
 tb/tb_clock_disp.sv | 132 +++++++++++++
 5 files changed

// File: rtl/clock_disp_pkg.sv
// Shared types and the BCD-to-7-segment decoder for the stopwatch timebase/display front-end.
// Segment codes are active-low and ordered {g,f,e,d,c,b,a}.
package clock_disp_pkg;

    typedef logic [3:0] bcd_t;
    typedef logic [6:0] seg_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [3:0] SEL_NONE  = 4'hF;

    function automatic seg_t seg_decode(input bcd_t value);
        seg_t seg;
        case (value)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/clock_disp_if.sv
// Display bus between the stopwatch core (master: digits) and clock_disp (slave: segments/anodes).
// The dp line exists only when CLOCK_DISP_DP_EN is defined.
interface clock_disp_if;
    import clock_disp_pkg::*;

    bcd_t       d0;
    bcd_t       d1;
    bcd_t       d2;
    bcd_t       d3;
    seg_t       dispDigit;
    logic [3:0] selector;
`ifdef CLOCK_DISP_DP_EN
    logic       dp;
`endif

    modport master (
        output d0, d1, d2, d3,
        input  dispDigit, selector
`ifdef CLOCK_DISP_DP_EN
        , input dp
`endif
    );

    modport slave (
        input  d0, d1, d2, d3,
        output dispDigit, selector
`ifdef CLOCK_DISP_DP_EN
        , output dp
`endif
    );

endinterface

// File: rtl/clock_disp_seg_mux.sv
// Four-digit scan multiplexer: advances the digit index on each fast strobe and registers
// the anode select and decoded segments for the new slot. dp separator with CLOCK_DISP_DP_EN.
module seg_mux
    import clock_disp_pkg::*;
(
    input  logic         clk,
    input  logic         RESET,
    input  logic         fast,
`ifdef CLOCK_DISP_DP_EN
    input  logic         blink,
`endif
    clock_disp_if.slave  bus
);

    logic [1:0] idx_r;
    logic [1:0] idx_next_s;
    bcd_t       digit_s;
    logic [3:0] sel_r;
    seg_t       seg_r;
`ifdef CLOCK_DISP_DP_EN
    logic       dp_r;
`endif

    // Next scan slot and the digit it shows; digits are only sampled when the slot changes.
    always_comb begin
        idx_next_s = idx_r + 2'd1;
        case (idx_next_s)
            2'd0:    digit_s = bus.d0;
            2'd1:    digit_s = bus.d1;
            2'd2:    digit_s = bus.d2;
            2'd3:    digit_s = bus.d3;
            default: digit_s = bus.d0;
        endcase
    end

    // Slot registers; display stays blank until the first fast strobe after reset.
    always_ff @(posedge clk) begin
        if (RESET) begin
            idx_r <= 2'd0;
            sel_r <= SEL_NONE;
            seg_r <= SEG_BLANK;
`ifdef CLOCK_DISP_DP_EN
            dp_r  <= 1'b1;
`endif
        end else if (fast) begin
            idx_r <= idx_next_s;
            sel_r <= ~(4'b0001 << idx_next_s);
            seg_r <= seg_decode(digit_s);
`ifdef CLOCK_DISP_DP_EN
            // Separator sits left of the minutes-units... i.e. lit with digit 2 while blinking.
            dp_r  <= ~((idx_next_s == 2'd2) && blink);
`endif
        end
    end

    assign bus.selector  = sel_r;
    assign bus.dispDigit = seg_r;
`ifdef CLOCK_DISP_DP_EN
    assign bus.dp        = dp_r;
`endif

endmodule

// File: rtl/clock_disp.sv
// Stopwatch timebase (fast / 2 Hz / 1 Hz strobes, 1 Hz blink) plus 4-digit display scan.
// Optional decimal-point separator is enabled by defining CLOCK_DISP_DP_EN.
module clock_disp
    import clock_disp_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int FAST_HZ     = 1000
) (
    input  logic         clk,
    input  logic         RESET,
    clock_disp_if.slave  bus,
    output logic         CLK_FAST,
    output logic         CLK_2HZ,
    output logic         CLK_1HZ,
    output logic         CLK_BLINK
);

    localparam int FAST_DIV = CLK_FREQ_HZ / FAST_HZ;
    localparam int SLOW_DIV = CLK_FREQ_HZ / 2;
    localparam int FW       = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
    localparam int SW       = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_DIV - 1);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_DIV - 1);

    logic [FW-1:0] fast_cnt_r;
    logic [SW-1:0] slow_cnt_r;
    logic          half_r;
    logic          fast_r;
    logic          hz2_r;
    logic          hz1_r;
    logic          blink_r;

    // Dividers, 1 Hz pairing and blink; strobes are high for the cycle after terminal count.
    always_ff @(posedge clk) begin
        if (RESET) begin
            fast_cnt_r <= '0;
            slow_cnt_r <= '0;
            half_r     <= 1'b0;
            fast_r     <= 1'b0;
            hz2_r      <= 1'b0;
            hz1_r      <= 1'b0;
            blink_r    <= 1'b0;
        end else begin
            if (fast_cnt_r == FAST_LAST) begin
                fast_cnt_r <= '0;
                fast_r     <= 1'b1;
            end else begin
                fast_cnt_r <= fast_cnt_r + FW'(1);
                fast_r     <= 1'b0;
            end
            if (slow_cnt_r == SLOW_LAST) begin
                slow_cnt_r <= '0;
                hz2_r      <= 1'b1;
                hz1_r      <= half_r;
                half_r     <= ~half_r;
            end else begin
                slow_cnt_r <= slow_cnt_r + SW'(1);
                hz2_r      <= 1'b0;
                hz1_r      <= 1'b0;
            end
            if (hz2_r) begin
                blink_r <= ~blink_r;
            end
        end
    end

    assign CLK_FAST  = fast_r;
    assign CLK_2HZ   = hz2_r;
    assign CLK_1HZ   = hz1_r;
    assign CLK_BLINK = blink_r;

    seg_mux u_seg_mux (
        .clk   (clk),
        .RESET (RESET),
        .fast  (fast_r),
`ifdef CLOCK_DISP_DP_EN
        .blink (blink_r),
`endif
        .bus   (bus)
    );

endmodule

// File: tb/tb_clock_disp.sv
// Directed bench for clock_disp at CLK_FREQ_HZ=8, FAST_HZ=4 (fast divide 2, 2 Hz divide 4).
module tb_clock_disp;
    import clock_disp_pkg::*;

    logic clk   = 1'b0;
    logic RESET = 1'b1;
    logic CLK_FAST;
    logic CLK_2HZ;
    logic CLK_1HZ;
    logic CLK_BLINK;

    int tests  = 0;
    int errors = 0;

    logic [6:0] seg_tab [4];

    clock_disp_if bus ();

    clock_disp #(
        .CLK_FREQ_HZ (8),
        .FAST_HZ     (4)
    ) dut (
        .clk       (clk),
        .RESET     (RESET),
        .bus       (bus.slave),
        .CLK_FAST  (CLK_FAST),
        .CLK_2HZ   (CLK_2HZ),
        .CLK_1HZ   (CLK_1HZ),
        .CLK_BLINK (CLK_BLINK)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sel"},   32'(bus.selector),  32'h0000000F);
        check({tag, "_seg"},   32'(bus.dispDigit), 32'h0000007F);
        check({tag, "_fast"},  32'(CLK_FAST),      32'd0);
        check({tag, "_2hz"},   32'(CLK_2HZ),       32'd0);
        check({tag, "_1hz"},   32'(CLK_1HZ),       32'd0);
        check({tag, "_blink"}, 32'(CLK_BLINK),     32'd0);
`ifdef CLOCK_DISP_DP_EN
        check({tag, "_dp"},    32'(bus.dp),        32'd1);
`endif
    endtask

    // Cycle c counts posedges after reset release; outputs sampled 1 time unit after the edge.
    task automatic run_scenario(input int ncyc, input int chg_at);
        int         k;
        logic [3:0] esel;
        logic [6:0] eseg;
        logic       edp;
        edp = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            check("fast",  32'(CLK_FAST),  32'(c % 2 == 0));
            check("2hz",   32'(CLK_2HZ),   32'(c % 4 == 0));
            check("1hz",   32'(CLK_1HZ),   32'(c % 8 == 0));
            check("blink", 32'(CLK_BLINK), 32'(((c - 1) / 4) % 2));
            if (c < 3) begin
                esel = 4'hF;
                eseg = 7'h7F;
            end else begin
                k    = ((c - 1) / 2) % 4;
                esel = ~(4'b0001 << k);
                eseg = seg_tab[k];
                if (c % 2 == 1) begin
                    edp = ~((k == 2) && (((c - 2) / 4) % 2 == 1));
                end
            end
            check("sel", 32'(bus.selector),  32'(esel));
            check("seg", 32'(bus.dispDigit), 32'(eseg));
`ifdef CLOCK_DISP_DP_EN
            check("dp",  32'(bus.dp),        32'(edp));
`endif
            if (c == chg_at) begin
                bus.d2     = 4'hC;
                seg_tab[2] = 7'h7F;
            end
        end
    endtask

    initial begin
        bit found;
        seg_tab[0] = 7'h79;
        seg_tab[1] = 7'h24;
        seg_tab[2] = 7'h30;
        seg_tab[3] = 7'h19;
        bus.d0 = 4'd1;
        bus.d1 = 4'd2;
        bus.d2 = 4'd3;
        bus.d3 = 4'd4;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        @(negedge clk);
        RESET = 1'b0;
        run_scenario(32, 16);

        // Wait for the digit-2 slot, then reset mid-scan.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.selector == 4'b1011) found = 1'b1;
        end
        check("find_sel2", 32'(found), 32'd1);
        check("pre_rst_blink", 32'(CLK_BLINK), 32'd1);
        RESET = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("midrst");
        repeat (2) @(posedge clk);
        bus.d2     = 4'd3;
        seg_tab[2] = 7'h30;
        @(negedge clk);
        RESET = 1'b0;
        run_scenario(16, 0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
